// File: rtl/alarm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alarm_pkg : shared state encoding and default parameters        |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package alarm_pkg;

  localparam int c_state_w = 3;

  typedef enum logic [c_state_w-1:0] {
    DISARMED    = 3'd0,
    ARMED       = 3'd1,
    ENTRY_DELAY = 3'd2,
    ALARM       = 3'd3
  } state_t;

  localparam int c_def_n_sensors     = 4;
  localparam int c_def_code_w        = 10;
  localparam int c_def_clk_hz        = 50_000_000;
  localparam int c_def_entry_delay_s = 5;
  localparam int c_def_max_tries     = 3;
  localparam int c_def_lockout_s     = 30;

endpackage
`default_nettype wire

// File: rtl/alarm_tick_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alarm_tick_gen : restartable 1 s tick, one pulse every CLK_HZ    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module alarm_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iRestart,
  output logic o1Hz
);

  localparam int c_cnt_w = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLK_HZ - 1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_cnt <= '0;
    end else if (iRestart || (r_cnt == c_last)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

  // Decoded from the count so the consumer acts exactly CLK_HZ edges after a restart.
  assign o1Hz = (r_cnt == c_last) && !iRestart;

endmodule
`default_nettype wire

// File: rtl/alarm_arm_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alarm_arm_ctrl : arm/disarm FSM with entry delay and code lockout|
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module alarm_arm_ctrl
  import alarm_pkg::*;
#(
  parameter int N_SENSORS     = c_def_n_sensors,
  parameter int CODE_W        = c_def_code_w,
  parameter int CLK_HZ        = c_def_clk_hz,
  parameter int ENTRY_DELAY_S = c_def_entry_delay_s,
  parameter int MAX_TRIES     = c_def_max_tries,
  parameter int LOCKOUT_S     = c_def_lockout_s
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic [CODE_W-1:0]    iCode,
  input  logic                 iCode_Load,
  input  logic                 iCode_Enter,
  input  logic [N_SENSORS-1:0] iSense,
  input  logic [N_SENSORS-1:0] iSense_Mask,
  output logic [2:0]           oState,
  output logic                 oArmed,
  output logic                 oVideo_On,
  output logic                 oAlarm,
  output logic [N_SENSORS-1:0] oTrip_Chan,
  output logic                 oLocked,
  output logic [7:0]           oCountdown
);

  localparam int c_fail_w = $clog2(MAX_TRIES + 1);
  localparam logic [c_fail_w-1:0] c_last_try = c_fail_w'(MAX_TRIES - 1);

  state_t               r_state;
  logic [N_SENSORS-1:0] r_sync1, r_sync2, r_hist;
  logic [1:0]           r_seed;
  logic [CODE_W-1:0]    r_code;
  logic                 r_code_valid;
  logic [c_fail_w-1:0]  r_fails;
  logic [7:0]           r_lock_s;

  logic [N_SENSORS-1:0] w_trip;
  logic w_trip_any, w_enter_ok, w_good, w_bad, w_lock_start;
  logic w_entry_start, w_disarm, w_entry_tick, w_lock_tick;

  // History only becomes meaningful once the synchronizer holds a real sample.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_hist  <= '0;
      r_seed  <= '0;
    end else begin
      r_sync1 <= iSense;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      if (r_seed != 2'd3) r_seed <= r_seed + 2'd1;
    end
  end

  assign w_trip     = (r_seed == 2'd3) ? ((r_sync2 ^ r_hist) & ~iSense_Mask) : '0;
  assign w_trip_any = |w_trip;

  assign w_enter_ok    = iCode_Enter && r_code_valid && !oLocked;
  assign w_good        = w_enter_ok && (iCode == r_code);
  assign w_bad         = w_enter_ok && (iCode != r_code);
  assign w_lock_start  = w_bad && (r_fails == c_last_try);
  assign w_entry_start = (r_state == ARMED) && w_trip_any && !w_good;
  assign w_disarm      = (r_state != DISARMED) && (w_good || (r_state > ALARM));

  alarm_tick_gen #(.CLK_HZ(CLK_HZ)) u_entry_tick (
    .iCLK(iCLK), .iRST(iRST), .iRestart(w_entry_start), .o1Hz(w_entry_tick)
  );

  alarm_tick_gen #(.CLK_HZ(CLK_HZ)) u_lock_tick (
    .iCLK(iCLK), .iRST(iRST), .iRestart(w_lock_start), .o1Hz(w_lock_tick)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_code       <= '0;
      r_code_valid <= 1'b0;
      r_fails      <= '0;
      r_lock_s     <= '0;
      oLocked      <= 1'b0;
    end else begin
      if (iCode_Load && !iCode_Enter && (r_state == DISARMED)) begin
        r_code       <= iCode;
        r_code_valid <= 1'b1;
      end
      if (oLocked) begin
        if (w_lock_tick) begin
          if (r_lock_s == 8'd1) begin
            oLocked  <= 1'b0;
            r_fails  <= '0;
            r_lock_s <= '0;
          end else begin
            r_lock_s <= r_lock_s - 8'd1;
          end
        end
      end else if (w_good) begin
        r_fails <= '0;
      end else if (w_bad) begin
        r_fails <= r_fails + c_fail_w'(1);
        if (w_lock_start) begin
          oLocked  <= 1'b1;
          r_lock_s <= 8'(LOCKOUT_S);
        end
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state    <= DISARMED;
      oArmed     <= 1'b0;
      oVideo_On  <= 1'b0;
      oAlarm     <= 1'b0;
      oTrip_Chan <= '0;
      oCountdown <= '0;
    end else begin
      case (r_state)
        DISARMED: if (w_good) begin
          r_state <= ARMED;
          oArmed  <= 1'b1;
        end
        ARMED: if (w_entry_start) begin
          r_state    <= ENTRY_DELAY;
          oVideo_On  <= 1'b1;
          oTrip_Chan <= w_trip;
          oCountdown <= 8'(ENTRY_DELAY_S);
        end
        ENTRY_DELAY: begin
          oTrip_Chan <= oTrip_Chan | w_trip;
          if (w_entry_tick) begin
            if (oCountdown <= 8'd1) begin
              r_state    <= ALARM;
              oAlarm     <= 1'b1;
              oCountdown <= '0;
            end else begin
              oCountdown <= oCountdown - 8'd1;
            end
          end
        end
        ALARM:   oTrip_Chan <= oTrip_Chan | w_trip;
        default: ;
      endcase
      // Disarm and illegal-state recovery override whatever the case above scheduled.
      if (w_disarm) begin
        r_state    <= DISARMED;
        oArmed     <= 1'b0;
        oVideo_On  <= 1'b0;
        oAlarm     <= 1'b0;
        oTrip_Chan <= '0;
        oCountdown <= '0;
      end
    end
  end

  assign oState = r_state;

endmodule
`default_nettype wire

// File: tb/tb_alarm_arm_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_alarm_arm_ctrl : scoreboard bench for alarm_arm_ctrl          |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_alarm_arm_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] code = '0;
  logic       load = 1'b0, enter = 1'b0;
  logic [3:0] sense = '0, mask = '0;
  logic [2:0] state;
  logic       armed, video, alarm, locked;
  logic [3:0] trip;
  logic [7:0] countdown;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  alarm_arm_ctrl #(
    .N_SENSORS(4), .CODE_W(10), .CLK_HZ(10),
    .ENTRY_DELAY_S(3), .MAX_TRIES(3), .LOCKOUT_S(2)
  ) dut (
    .iCLK(clk), .iRST(rst), .iCode(code), .iCode_Load(load), .iCode_Enter(enter),
    .iSense(sense), .iSense_Mask(mask),
    .oState(state), .oArmed(armed), .oVideo_On(video), .oAlarm(alarm),
    .oTrip_Chan(trip), .oLocked(locked), .oCountdown(countdown)
  );

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_errors = 0;
  string sel_name[7] = '{"state", "armed", "video", "alarm", "trip", "locked", "countdown"};
  int    c, r;

  function automatic logic [31:0] actual(int sel);
    case (sel)
      0:       return 32'(state);
      1:       return 32'(armed);
      2:       return 32'(video);
      3:       return 32'(alarm);
      4:       return 32'(trip);
      5:       return 32'(locked);
      6:       return 32'(countdown);
      default: return '0;
    endcase
  endfunction

  function automatic void expect_at(int at, int sel, int v, string nm);
    exp_t e;
    e.cyc = at; e.sel = sel; e.exp = 32'(v); e.name = nm;
    sb.push_back(e);
  endfunction

  // Monitor: pops every expectation due in the current cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        n_checks++;
        if (sb[i].cyc < cyc) begin
          n_errors++;
          $display("FAIL %s/%s: not sampled at cycle %0d", sb[i].name, sel_name[sb[i].sel], sb[i].cyc);
        end else if (actual(sb[i].sel) !== sb[i].exp) begin
          n_errors++;
          $display("FAIL %s/%s cycle %0d: actual %0d expected %0d", sb[i].name,
                   sel_name[sb[i].sel], cyc, actual(sb[i].sel), sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    step(3);
    for (int s = 0; s < 7; s++) expect_at(cyc, s, 0, "reset");
    rst = 1'b0;
    step(5);

    // Trip while disarmed is ignored
    sense[3] = 1'b1; c = cyc;
    expect_at(c + 3, 0, 0, "disarmed_trip");
    expect_at(c + 4, 4, 0, "disarmed_trip");
    step(5);

    // Load then arm
    code = 10'h2A5; load = 1'b1; step(1); load = 1'b0;
    enter = 1'b1; c = cyc;
    expect_at(c, 0, 0, "load_only");
    expect_at(c + 1, 0, 1, "arm");
    expect_at(c + 1, 1, 1, "arm");
    step(1); enter = 1'b0; step(3);

    // Masked channel causes no trip
    mask = 4'b0001; sense[0] = ~sense[0]; c = cyc;
    expect_at(c + 3, 0, 1, "masked");
    expect_at(c + 6, 4, 0, "masked");
    step(8); mask = 4'b0000; step(3);

    // Trip on channel 2, entry delay, escalation to alarm
    sense[2] = ~sense[2]; c = cyc;
    expect_at(c + 2, 0, 1, "latency");
    expect_at(c + 3, 0, 2, "entry");
    expect_at(c + 3, 2, 1, "entry");
    expect_at(c + 3, 4, 4, "entry");
    expect_at(c + 3, 6, 3, "entry");
    expect_at(c + 13, 6, 2, "tick1");
    expect_at(c + 23, 6, 1, "tick2");
    expect_at(c + 32, 3, 0, "pre_alarm");
    expect_at(c + 33, 3, 1, "alarm");
    expect_at(c + 33, 0, 3, "alarm");
    expect_at(c + 33, 6, 0, "alarm");
    step(5);
    sense[1] = ~sense[1];
    expect_at(cyc + 3, 4, 6, "or_trip");
    expect_at(cyc + 3, 6, 3, "no_restart");
    step(c + 36 - cyc);
    enter = 1'b1; r = cyc;
    expect_at(r + 1, 0, 0, "disarm_alarm");
    expect_at(r + 1, 3, 0, "disarm_alarm");
    expect_at(r + 1, 2, 0, "disarm_alarm");
    expect_at(r + 1, 4, 0, "disarm_alarm");
    step(1); enter = 1'b0; step(2);

    // Disarm during entry delay at countdown 1
    enter = 1'b1; step(1); enter = 1'b0; step(2);
    sense[2] = ~sense[2]; c = cyc;
    expect_at(c + 3, 0, 2, "entry2");
    expect_at(c + 23, 6, 1, "entry2_cd1");
    step(25);
    enter = 1'b1;
    expect_at(c + 26, 0, 0, "disarm_entry");
    expect_at(c + 26, 2, 0, "disarm_entry");
    expect_at(c + 26, 4, 0, "disarm_entry");
    expect_at(c + 26, 6, 0, "disarm_entry");
    expect_at(c + 40, 3, 0, "no_alarm");
    step(1); enter = 1'b0; step(16);

    // Correct enter coincides with a trip: disarm wins
    enter = 1'b1; step(1); enter = 1'b0; step(2);
    expect_at(cyc, 0, 1, "rearm");
    sense[1] = ~sense[1]; c = cyc;
    expect_at(c + 3, 0, 0, "race");
    expect_at(c + 3, 4, 0, "race");
    expect_at(c + 6, 0, 0, "race_after");
    expect_at(c + 6, 2, 0, "race_after");
    step(2); enter = 1'b1; step(1); enter = 1'b0; step(5);

    // Three wrong codes lock out entry for 20 cycles
    code = 10'h001;
    for (int k = 0; k < 3; k++) begin
      enter = 1'b1; c = cyc;
      expect_at(c + 1, 0, 0, "wrong_code");
      expect_at(c + 1, 5, (k == 2) ? 1 : 0, "lock");
      step(1); enter = 1'b0; step(2);
    end
    r = c + 1;
    expect_at(r + 19, 5, 1, "lock_hold");
    expect_at(r + 20, 5, 0, "lock_end");
    code = 10'h2A5;
    step(r + 5 - cyc);
    enter = 1'b1;
    expect_at(r + 6, 0, 0, "locked_ignore");
    step(1); enter = 1'b0;
    step(r + 21 - cyc);
    enter = 1'b1;
    expect_at(r + 22, 0, 1, "unlock_arm");
    expect_at(r + 22, 1, 1, "unlock_arm");
    step(1); enter = 1'b0; step(2);

    // Asynchronous reset mid-countdown, no spurious trip afterwards
    sense[3] = ~sense[3]; c = cyc;
    expect_at(c + 3, 0, 2, "entry3");
    step(8);
    #2 rst = 1'b1;
    for (int s = 0; s < 7; s++) expect_at(cyc, s, 0, "async_reset");
    step(2);
    rst = 1'b0; r = cyc;
    expect_at(r + 2, 0, 1, "post_reset_arm");
    expect_at(r + 4, 0, 1, "no_spurious");
    expect_at(r + 6, 4, 0, "no_spurious");
    expect_at(r + 9, 0, 1, "no_spurious");
    load = 1'b1; step(1); load = 1'b0;
    enter = 1'b1; step(1); enter = 1'b0;
    step(12);

    foreach (sb[i]) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s/%s: never checked (cycle %0d)", sb[i].name, sel_name[sb[i].sel], sb[i].cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
